// File: rtl/reply_seq_if.sv
// Handshake bundle between reply_seq, the command dispatcher and the UART rx/tx cores.
interface reply_seq_if #(
  parameter int CNT_BYTES = 2
);
  logic                   activate;
  logic                   done;
  logic                   aborted;
  logic [8*CNT_BYTES-1:0] sent;
  logic                   rx_ready;
  logic [7:0]             rx_data;
  logic                   tx_active;
  logic                   tx_done;
  logic                   tx_start;
  logic [7:0]             tx_data;

  // Dispatcher/UART side.
  modport master (
    output activate, rx_ready, rx_data, tx_active, tx_done,
    input  done, aborted, sent, tx_start, tx_data
  );

  // Command handler side.
  modport slave (
    input  activate, rx_ready, rx_data, tx_active, tx_done,
    output done, aborted, sent, tx_start, tx_data
  );
endinterface

// File: rtl/reply_seq.sv
// UART command handler: reads a mode byte and a little-endian length, then
// replies with generated bytes and an optional XOR checksum trailer.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | not owned by dispatcher; done/aborted low
// HDR_MODE | waiting for the mode byte
// HDR_CNT  | collecting the length bytes, LSB first
// SEND     | waiting for an idle transmitter, then launching a data byte
// WAIT_TX  | data byte in flight; abort requests are latched here
// SEND_CHK | waiting for an idle transmitter, then launching the checksum
// WAIT_CHK | checksum byte in flight
// DONE     | command finished; done held until activate drops
module reply_seq #(
  parameter int         CNT_BYTES  = 2,
  parameter logic [7:0] START_VAL  = 8'h00,
  parameter logic [7:0] ABORT_BYTE = 8'h55,
  parameter int         CHECKSUM   = 1
) (
  input logic        clk,
  input logic        reset,
  reply_seq_if.slave bus
);

  localparam int CW = 8 * CNT_BYTES;
  // An all-zero LFSR would lock up, so a zero start value seeds it with 1.
  localparam logic [7:0] LFSR_SEED = (START_VAL == 8'h00) ? 8'h01 : START_VAL;

  typedef enum logic [2:0] {
    IDLE, HDR_MODE, HDR_CNT, SEND, WAIT_TX, SEND_CHK, WAIT_CHK, DONE
  } state_t;

  state_t          state;
  logic [1:0]      mode;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [2:0]      idx;
  logic [7:0]      val;
  logic [7:0]      chk;
  logic            abort_pend;
  logic            abort_hit;
  logic            last_byte;

  function automatic logic [7:0] advance(input logic [1:0] m, input logic [7:0] v);
    logic [7:0] r;
    unique case (m)
      2'd0:    r = v + 8'd1;
      2'd1:    r = v - 8'd1;
      2'd2:    r = v;
      default: r = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endcase
    return r;
  endfunction

  assign abort_hit = bus.rx_ready && (bus.rx_data == ABORT_BYTE);
  assign last_byte = (idx == 3'(CNT_BYTES - 1));

  // Length register with the incoming byte merged at the current index.
  always_comb begin
    count_next = count;
    for (int i = 0; i < CNT_BYTES; i++) begin
      if (idx == 3'(i)) count_next[8*i +: 8] = bus.rx_data;
    end
  end

  // Sequencer with registered outputs; tx_start is a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mode        <= 2'd0;
      count       <= '0;
      idx         <= 3'd0;
      val         <= 8'h00;
      chk         <= 8'h00;
      abort_pend  <= 1'b0;
      bus.done     <= 1'b0;
      bus.aborted  <= 1'b0;
      bus.sent     <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= 8'h00;
    end else begin
      bus.tx_start <= 1'b0;
      if (state != IDLE && !bus.activate) begin
        state       <= IDLE;
        bus.done    <= 1'b0;
        bus.aborted <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            bus.done    <= 1'b0;
            bus.aborted <= 1'b0;
            if (bus.activate) begin
              state      <= HDR_MODE;
              bus.sent   <= '0;
              count      <= '0;
              chk        <= 8'h00;
              idx        <= 3'd0;
              abort_pend <= 1'b0;
            end
          end
          HDR_MODE: begin
            if (bus.rx_ready) begin
              mode  <= bus.rx_data[1:0];
              state <= HDR_CNT;
            end
          end
          HDR_CNT: begin
            if (bus.rx_ready) begin
              count <= count_next;
              idx   <= idx + 3'd1;
              if (last_byte) begin
                val <= (mode == 2'd3) ? LFSR_SEED : START_VAL;
                if (count_next == '0) begin
                  state    <= DONE;
                  bus.done <= 1'b1;
                end else begin
                  state <= SEND;
                end
              end
            end
          end
          SEND: begin
            if (abort_hit) begin
              state       <= DONE;
              bus.done    <= 1'b1;
              bus.aborted <= 1'b1;
            end else if (!bus.tx_active) begin
              bus.tx_start <= 1'b1;
              bus.tx_data  <= val;
              chk          <= chk ^ val;
              bus.sent     <= bus.sent + CW'(1);
              val          <= advance(mode, val);
              state        <= WAIT_TX;
            end
          end
          WAIT_TX: begin
            if (abort_hit) abort_pend <= 1'b1;
            if (bus.tx_done) begin
              if (abort_pend || abort_hit) begin
                state       <= DONE;
                bus.done    <= 1'b1;
                bus.aborted <= 1'b1;
              end else if (bus.sent == count) begin
                if (CHECKSUM != 0) begin
                  state <= SEND_CHK;
                end else begin
                  state    <= DONE;
                  bus.done <= 1'b1;
                end
              end else begin
                state <= SEND;
              end
            end
          end
          SEND_CHK: begin
            if (!bus.tx_active) begin
              bus.tx_start <= 1'b1;
              bus.tx_data  <= chk;
              state        <= WAIT_CHK;
            end
          end
          WAIT_CHK: begin
            if (bus.tx_done) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
          DONE: begin
            bus.done <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_reply_seq.sv
// Bench for reply_seq: directed and random commands against a list-based reply model.
module tb_reply_seq;

  localparam int         CNT_BYTES  = 2;
  localparam logic [7:0] START_VAL  = 8'h00;
  localparam logic [7:0] ABORT_BYTE = 8'h55;
  localparam int         CHECKSUM   = 1;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   tx_q[$];
  int   exp_q[$];
  bit   prev_start = 1'b0;
  int   busy = 0;

  reply_seq_if #(.CNT_BYTES(CNT_BYTES)) bus ();

  reply_seq #(
    .CNT_BYTES(CNT_BYTES), .START_VAL(START_VAL),
    .ABORT_BYTE(ABORT_BYTE), .CHECKSUM(CHECKSUM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART transmitter model: records launched bytes, stays busy 2..5 cycles, pulses tx_done.
  initial begin
    bus.tx_active = 1'b0;
    bus.tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          bus.tx_active = 1'b0;
          bus.tx_done   = 1'b1;
        end
      end
      if (bus.tx_start === 1'b1) begin
        check("tx_start_while_active", 32'(bus.tx_active), 32'd0);
        check("tx_start_back_to_back", 32'(prev_start), 32'd0);
        tx_q.push_back(int'(bus.tx_data));
        bus.tx_active = 1'b1;
        busy = $urandom_range(2, 5);
      end
      prev_start = (bus.tx_start === 1'b1);
    end
  end

  // Expected reply from the command rules: n data bytes, then XOR trailer if requested.
  task automatic build_exp(input int mode, input int n, input bit with_chk);
    int v;
    int c;
    v = (mode == 3 && START_VAL == 8'h00) ? 1 : int'(START_VAL);
    c = 0;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      c = c ^ v;
      case (mode)
        0: v = (v + 1) % 256;
        1: v = (v + 255) % 256;
        2: v = v;
        default: v = ((v * 2) % 256) + (((v >> 7) ^ (v >> 5) ^ (v >> 4) ^ (v >> 3)) & 1);
      endcase
    end
    if (with_chk) exp_q.push_back(c);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    bus.rx_ready = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_tx(input int n, input string tag);
    int c = 0;
    while (tx_q.size() < n && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_tx_timeout"}, 32'(tx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (bus.done !== 1'b1 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done"}, 32'(bus.done), 32'd1);
  endtask

  task automatic start_hdr(input logic [7:0] mode_b, input int count);
    tx_q.delete();
    @(negedge clk);
    bus.activate = 1'b1;
    send_rx(mode_b);
    send_rx(8'(count));
    send_rx(8'(count >> 8));
  endtask

  task automatic run_cmd(input string tag, input logic [7:0] mode_b, input int count,
                         input int abort_after, input bit noise);
    int n;
    logic [7:0] nb;
    n = (abort_after > 0) ? abort_after : count;
    build_exp(int'(mode_b[1:0]), n, (abort_after == 0) && (count > 0) && (CHECKSUM != 0));
    start_hdr(mode_b, count);
    if (count == 0) begin
      check({tag, "_zero_done_next"}, 32'(bus.done), 32'd1);
      check({tag, "_zero_no_tx"}, 32'(tx_q.size()), 32'd0);
    end
    if (abort_after > 0) begin
      wait_tx(abort_after, tag);
      send_rx(ABORT_BYTE);
    end else if (noise && count > 0) begin
      wait_tx(1, tag);
      nb = 8'($urandom);
      if (nb == ABORT_BYTE) nb = nb + 8'd1;
      send_rx(nb);
    end
    wait_done(tag);
    repeat (8) @(negedge clk);
    check({tag, "_done_held"}, 32'(bus.done), 32'd1);
    check({tag, "_aborted"}, 32'(bus.aborted), 32'(abort_after > 0));
    check({tag, "_sent"}, 32'(bus.sent), 32'(n));
    check({tag, "_tx_len"}, 32'(tx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < tx_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(tx_q[i]), 32'(exp_q[i]));
    bus.activate = 1'b0;
    @(negedge clk);
    check({tag, "_idle_done"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_aborted"}, 32'(bus.aborted), 32'd0);
    check({tag, "_idle_sent_hold"}, 32'(bus.sent), 32'(n));
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int sz;
    int mode;
    int count;
    int ab;
    logic [7:0] mb;
    reset         = 1'b1;
    bus.activate  = 1'b0;
    bus.rx_ready  = 1'b0;
    bus.rx_data   = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_aborted", 32'(bus.aborted), 32'd0);
    check("rst_sent", 32'(bus.sent), 32'd0);
    check("rst_tx_start", 32'(bus.tx_start), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_cmd("up3", 8'h00, 3, 0, 1'b0);
    run_cmd("down4_hdr55", 8'h55, 4, 0, 1'b0);
    run_cmd("lfsr5", 8'h03, 5, 0, 1'b0);
    run_cmd("fill4_noise", 8'h02, 4, 0, 1'b1);
    run_cmd("zero", 8'h00, 0, 0, 1'b0);
    run_cmd("abort2", 8'h00, 256, 2, 1'b0);
    run_cmd("abort_last", 8'h02, 3, 3, 1'b0);

    // Dispatcher withdraws ownership mid-reply.
    start_hdr(8'h00, 10);
    wait_tx(2, "drop");
    bus.activate = 1'b0;
    @(negedge clk);
    check("drop_tx_start", 32'(bus.tx_start), 32'd0);
    check("drop_done", 32'(bus.done), 32'd0);
    sz = tx_q.size();
    repeat (20) @(negedge clk);
    check("drop_no_more_tx", 32'(tx_q.size()), 32'(sz));
    run_cmd("after_drop", 8'h01, 3, 0, 1'b0);

    // Reset pulsed mid-reply.
    start_hdr(8'h03, 10);
    wait_tx(3, "rst_mid");
    reset = 1'b1;
    bus.activate = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_done", 32'(bus.done), 32'd0);
    check("rstmid_aborted", 32'(bus.aborted), 32'd0);
    check("rstmid_sent", 32'(bus.sent), 32'd0);
    check("rstmid_tx_start", 32'(bus.tx_start), 32'd0);
    check("rstmid_tx_data", 32'(bus.tx_data), 32'd0);
    sz = tx_q.size();
    repeat (20) @(negedge clk);
    check("rstmid_no_more_tx", 32'(tx_q.size()), 32'(sz));
    run_cmd("after_rst", 8'h00, 2, 0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      mode  = $urandom_range(0, 3);
      mb    = 8'($urandom);
      mb[1:0] = 2'(mode);
      count = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 8);
      ab    = (count > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, count) : 0;
      run_cmd($sformatf("rnd%0d", i), mb, count, ab, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
